// File: rtl/if_id_reg.sv
// IF/ID pipeline boundary register.
// Holds fetched {instruction, address} pairs for the decode stage behind a
// valid/ready handshake. A one-entry skid register absorbs decode
// back-pressure, so ready_o can come straight from a flop and no entry is
// dropped or duplicated. A flush discards everything held and drives a NOP
// bubble.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] RST_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        valid_o,
    input  logic        ready_i
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // main register invalid
        ONE   = 2'd1,  // main valid, skid empty
        FULL  = 2'd2   // main and skid valid (skid is the younger entry)
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] main_inst, main_inst_nxt;
    logic [31:0] main_addr, main_addr_nxt;
    logic [31:0] skid_inst, skid_inst_nxt;
    logic [31:0] skid_addr, skid_addr_nxt;
    logic        valid_q, ready_q;
    logic        fire_in, fire_out;

    assign fire_in  = valid_i & ready_q;
    assign fire_out = valid_q & ready_i;

    // Next-state and next-contents decode; flush overrides every transition.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_nxt     = state;
        main_inst_nxt = main_inst;
        main_addr_nxt = main_addr;
        skid_inst_nxt = skid_inst;
        skid_addr_nxt = skid_addr;

        if (flush_i) begin
            state_nxt     = EMPTY;
            main_inst_nxt = NOP_INST;
            main_addr_nxt = RST_ADDR;
            skid_inst_nxt = NOP_INST;
            skid_addr_nxt = RST_ADDR;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (fire_in) begin
                        state_nxt     = ONE;
                        main_inst_nxt = inst_i;
                        main_addr_nxt = inst_addr_i;
                    end
                end
                ONE: begin
                    if (fire_in && fire_out) begin
                        main_inst_nxt = inst_i;
                        main_addr_nxt = inst_addr_i;
                    end else if (fire_in) begin
                        state_nxt     = FULL;
                        skid_inst_nxt = inst_i;
                        skid_addr_nxt = inst_addr_i;
                    end else if (fire_out) begin
                        // Bubble: instruction becomes NOP, address keeps the
                        // last delivered value.
                        state_nxt     = EMPTY;
                        main_inst_nxt = NOP_INST;
                    end
                end
                FULL: begin
                    // ready_o is low here, so no new entry can arrive.
                    if (fire_out) begin
                        state_nxt     = ONE;
                        main_inst_nxt = skid_inst;
                        main_addr_nxt = skid_addr;
                        skid_inst_nxt = NOP_INST;
                        skid_addr_nxt = RST_ADDR;
                    end
                end
                default: begin
                    state_nxt     = EMPTY;
                    main_inst_nxt = NOP_INST;
                    main_addr_nxt = RST_ADDR;
                end
            endcase
        end
    end

    // State, storage and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the skid and main data registers are reset too, so the
            // outputs are never X after reset and a stale skid is never seen.
            state     <= EMPTY;
            main_inst <= NOP_INST;
            main_addr <= RST_ADDR;
            skid_inst <= NOP_INST;
            skid_addr <= RST_ADDR;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state     <= state_nxt;
            main_inst <= main_inst_nxt;
            main_addr <= main_addr_nxt;
            skid_inst <= skid_inst_nxt;
            skid_addr <= skid_addr_nxt;
            valid_q   <= (state_nxt != EMPTY);
            ready_q   <= (state_nxt != FULL);
        end
    end

    assign inst_o      = main_inst;
    assign inst_addr_o = main_addr;
    assign valid_o     = valid_q;
    assign ready_o     = ready_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios followed by a long
// randomized run, all compared against a queue-based reference model.
module tb_if_id_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RST = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        valid_o;
    logic        ready_i;

    if_id_reg #(
        .NOP_INST(NOP),
        .RST_ADDR(RST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_i     (inst_i),
        .inst_addr_i(inst_addr_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .flush_i    (flush_i),
        .inst_o     (inst_o),
        .inst_addr_o(inst_addr_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a FIFO of at most two accepted, not yet consumed
    // entries plus the address last shown to decode.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } entry_t;

    entry_t      q[$];
    logic [31:0] last_addr;
    int          checks;
    int          errors;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_addr = RST;
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] e_inst;
        logic [31:0] e_addr;
        e_inst = (q.size() > 0) ? q[0].inst : NOP;
        e_addr = (q.size() > 0) ? q[0].addr : last_addr;
        check32({tag, "_valid"}, {31'b0, valid_o}, {31'b0, q.size() > 0});
        check32({tag, "_ready"}, {31'b0, ready_o}, {31'b0, q.size() < 2});
        check32({tag, "_inst"}, inst_o, e_inst);
        check32({tag, "_addr"}, inst_addr_o, e_addr);
    endtask

    // One clock cycle: drive inputs (called just after a falling edge),
    // advance the model, then check on the next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [31:0] i,
                         input logic [31:0] a, input logic r, input logic f);
        logic        hold_chk;
        logic [31:0] p_inst, p_addr;
        logic        m_fire_in, m_fire_out;
        valid_i     = v;
        inst_i      = i;
        inst_addr_i = a;
        ready_i     = r;
        flush_i     = f;
        hold_chk    = valid_o && !r && !f;
        p_inst      = inst_o;
        p_addr      = inst_addr_o;
        m_fire_out  = (q.size() > 0) && r;
        m_fire_in   = v && (q.size() < 2);
        if (f) begin
            model_reset();
        end else begin
            if (m_fire_out) void'(q.pop_front());
            if (m_fire_in) q.push_back('{inst: i, addr: a});
            if (q.size() > 0) last_addr = q[0].addr;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
        if (hold_chk) begin
            check32({tag, "_stable_valid"}, {31'b0, valid_o}, 32'd1);
            check32({tag, "_stable_inst"}, inst_o, p_inst);
            check32({tag, "_stable_addr"}, inst_addr_o, p_addr);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        valid_i     = 1'b1;
        inst_i      = 32'hDEAD_BEEF;
        inst_addr_i = 32'h0000_0040;
        ready_i     = 1'b1;
        flush_i     = 1'b0;
        model_reset();

        // Reset held with valid_i high: nothing may be captured.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("rst_hold");
        valid_i = 1'b0;
        rst_n   = 1'b1;
        #1;
        check_outputs("rst_release");
        cycle("rst_idle", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Streaming at full rate.
        cycle("stream0", 1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
        check32("stream0_exp_inst", inst_o, 32'h0050_0093);
        cycle("stream1", 1'b1, 32'h0010_0113, 32'h4, 1'b1, 1'b0);
        check32("stream1_exp_addr", inst_addr_o, 32'h4);
        cycle("stream2", 1'b1, 32'h0020_81B3, 32'h8, 1'b1, 1'b0);
        check32("stream2_exp_inst", inst_o, 32'h0020_81B3);
        cycle("stream_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check32("stream_drain_addr", inst_addr_o, 32'h8);

        // Back-pressure: 0x0 in main, 0x4 in skid, 0x8 held off.
        cycle("bp0", 1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
        cycle("bp1", 1'b1, 32'h0010_0113, 32'h4, 1'b0, 1'b0);
        check32("bp1_not_ready", {31'b0, ready_o}, 32'd0);
        for (int k = 0; k < 3; k++)
            cycle("bp_hold", 1'b1, 32'h0020_81B3, 32'h8, 1'b0, 1'b0);
        cycle("bp_rel0", 1'b1, 32'h0020_81B3, 32'h8, 1'b1, 1'b0);
        check32("bp_rel0_addr", inst_addr_o, 32'h4);
        cycle("bp_rel1", 1'b1, 32'h0020_81B3, 32'h8, 1'b1, 1'b0);
        check32("bp_rel1_addr", inst_addr_o, 32'h8);
        cycle("bp_rel2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while FULL with a valid input presented.
        cycle("fl_fill0", 1'b1, 32'h1111_1111, 32'h20, 1'b0, 1'b0);
        cycle("fl_fill1", 1'b1, 32'h2222_2222, 32'h24, 1'b0, 1'b0);
        cycle("fl_flush", 1'b1, 32'h3333_3333, 32'hC, 1'b0, 1'b1);
        check32("fl_flush_addr", inst_addr_o, 32'h0);
        cycle("fl_flush2", 1'b1, 32'h3333_3333, 32'hC, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            cycle("fl_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Single entry drains to a NOP bubble that keeps its address.
        cycle("drain0", 1'b1, 32'h0000_0033, 32'h10, 1'b1, 1'b0);
        cycle("drain1", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check32("drain1_bubble_addr", inst_addr_o, 32'h10);
        cycle("drain2", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle with entries held.
        cycle("mr_fill0", 1'b1, 32'hAAAA_0001, 32'h30, 1'b0, 1'b0);
        cycle("mr_fill1", 1'b1, 32'hAAAA_0002, 32'h34, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("mid_rst_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 10000; n++) begin
            cycle("rand",
                  $urandom_range(0, 9) < 7,
                  $urandom,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
